// File: rtl/sdr_write.sv
// -----------------------------------------------------------------------------
// sdr_write
//   SDRAM write engine behind sdr_ctl. Each request writes one 64-bit word to an
//   x16 SDRAM as a single BL=4 burst: ACTIVE -> WRITE -> PRECHARGE, then a
//   one-cycle done_w pulse. All outputs are registered and feed the SDRAM pin
//   mux (selected by sdr_ctl when bus_sel == 2'b10).
//
//   Parameters
//     T_RCD  ACTIVE->WRITE delay in clk cycles (1..15)
//     T_WR   last write beat -> PRECHARGE in clk cycles (1..15)
//     T_RP   PRECHARGE -> done in clk cycles (1..15)
//
//   Ports
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     req_w    in   write request level, sampled only while idle
//     laddr_w  in   [24:23] bank, [22:10] row, [9:0] column ([1:0] ignored)
//     data_w   in   write data, [15:0] is burst beat 0
//     done_w   out  one-cycle pulse when the write sequence completes
//     busy     out  high from the ACTIVE cycle through the done_w cycle
//     cmd      out  {cs_n, ras_n, cas_n, we_n}
//     ba       out  bank address
//     addr     out  SDRAM address bus
//     dq_out   out  write data to DQ pins
//     dq_oe    out  DQ output enable
//
//   Build option
//     SDR_WR_AUTOPRE_EN : WRITE is issued with auto-precharge (addr[10]=1) and
//                         the explicit PRECHARGE slot drives NOP instead.
//                         done_w timing is identical in both builds.
// -----------------------------------------------------------------------------
module sdr_write #(
   parameter int T_RCD = 2,
   parameter int T_WR  = 2,
   parameter int T_RP  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_w,
   input  logic [24:0] laddr_w,
   input  logic [63:0] data_w,
   output logic        done_w,
   output logic        busy,
   output logic [3:0]  cmd,
   output logic [1:0]  ba,
   output logic [12:0] addr,
   output logic [15:0] dq_out,
   output logic        dq_oe
);

   localparam logic [3:0] C_NOP   = 4'b0111;
   localparam logic [3:0] C_ACT   = 4'b0011;
   localparam logic [3:0] C_WRITE = 4'b0100;
   localparam logic [3:0] C_PRE   = 4'b0010;

   // Counter load values: each timed state ends when the counter reaches 0,
   // so a state lasting N cycles loads N-1. RCD lasts T_RCD-1 cycles and TRP
   // lasts T_RP-1 cycles, hence the -2 loads (unused when the state is skipped).
   localparam logic [3:0] L_RCD_LD  = 4'(T_RCD - 2);
   localparam logic [3:0] L_BEAT_LD = 4'd3;
   localparam logic [3:0] L_TWR_LD  = 4'(T_WR - 1);
   localparam logic [3:0] L_TRP_LD  = 4'(T_RP - 2);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ACT  = 3'd1,
      S_RCD  = 3'd2,
      S_WR   = 3'd3,
      S_TWR  = 3'd4,
      S_PRE  = 3'd5,
      S_TRP  = 3'd6,
      S_DONE = 3'd7
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [24:2] r_laddr;
   logic [63:0] r_data;

   logic [3:0]  r_cmd;
   logic [1:0]  r_ba;
   logic [12:0] r_addr;
   logic [15:0] r_dq_out;
   logic        r_dq_oe;
   logic        r_done;
   logic        r_busy;

   state_t      w_next_state;
   logic [3:0]  w_next_cnt;
   logic        w_cnt_zero;
   logic        w_accept;
   logic [24:2] w_laddr;
   logic [1:0]  w_bank;
   logic [3:0]  w_cmd;
   logic [1:0]  w_ba;
   logic [12:0] w_addr;
   logic [15:0] w_dq_out;
   logic        w_dq_oe;
   logic        w_done;
   logic        w_busy;

   // Column bits [1:0] never reach the SDRAM: bursts are always 4-aligned.
   logic        w_unused_col_lsb;
   assign w_unused_col_lsb = &{1'b0, laddr_w[1:0]};

   assign w_cnt_zero = (r_cnt == 4'd0);
   assign w_accept   = (r_state == S_IDLE) && req_w;

   // The ACTIVE cycle is produced on the same edge that latches the request,
   // so its bank/row must come straight from the input port.
   assign w_laddr = (r_state == S_IDLE) ? laddr_w[24:2] : r_laddr;
   assign w_bank  = w_laddr[24:23];

   // Next-state and wait-counter logic.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (req_w) begin
               w_next_state = S_ACT;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_ACT: begin
            if (T_RCD == 1) begin
               w_next_state = S_WR;
               w_next_cnt   = L_BEAT_LD;
            end else begin
               w_next_state = S_RCD;
               w_next_cnt   = L_RCD_LD;
            end
         end
         S_RCD: begin
            if (w_cnt_zero) begin
               w_next_state = S_WR;
               w_next_cnt   = L_BEAT_LD;
            end else begin
               w_next_cnt   = r_cnt - 4'd1;
            end
         end
         S_WR: begin
            if (w_cnt_zero) begin
               w_next_state = S_TWR;
               w_next_cnt   = L_TWR_LD;
            end else begin
               w_next_cnt   = r_cnt - 4'd1;
            end
         end
         S_TWR: begin
            if (w_cnt_zero) begin
               w_next_state = S_PRE;
            end else begin
               w_next_cnt   = r_cnt - 4'd1;
            end
         end
         S_PRE: begin
            if (T_RP == 1) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_TRP;
               w_next_cnt   = L_TRP_LD;
            end
         end
         S_TRP: begin
            if (w_cnt_zero) begin
               w_next_state = S_DONE;
            end else begin
               w_next_cnt   = r_cnt - 4'd1;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
            w_next_cnt   = 4'd0;
         end
      endcase
   end

   // Output decode from the upcoming state, so the registered outputs line up
   // with the state they belong to. In WR the counter runs 3..0, giving beat 0..3.
   always_comb begin
      w_cmd    = C_NOP;
      w_ba     = 2'd0;
      w_addr   = 13'd0;
      w_dq_out = 16'd0;
      w_dq_oe  = 1'b0;
      w_done   = 1'b0;
      w_busy   = (w_next_state != S_IDLE);
      case (w_next_state)
         S_ACT: begin
            w_cmd  = C_ACT;
            w_ba   = w_bank;
            w_addr = w_laddr[22:10];
         end
         S_WR: begin
            w_dq_oe = 1'b1;
            case (w_next_cnt)
               4'd3: begin
                  w_cmd    = C_WRITE;
                  w_ba     = w_bank;
`ifdef SDR_WR_AUTOPRE_EN
                  w_addr   = {2'b00, 1'b1, w_laddr[9:2], 2'b00};
`else
                  w_addr   = {2'b00, 1'b0, w_laddr[9:2], 2'b00};
`endif
                  w_dq_out = r_data[15:0];
               end
               4'd2: begin
                  w_dq_out = r_data[31:16];
               end
               4'd1: begin
                  w_dq_out = r_data[47:32];
               end
               default: begin
                  w_dq_out = r_data[63:48];
               end
            endcase
         end
         S_PRE: begin
`ifdef SDR_WR_AUTOPRE_EN
            w_cmd = C_NOP;
            w_ba  = 2'd0;
`else
            w_cmd = C_PRE;
            w_ba  = w_bank;
`endif
            w_addr = 13'd0;
         end
         S_DONE: begin
            w_done = 1'b1;
         end
         default: begin
            w_cmd = C_NOP;
         end
      endcase
   end

   // State, wait counter and request capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_laddr <= 23'd0;
         r_data  <= 64'd0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         if (w_accept) begin
            r_laddr <= laddr_w[24:2];
            r_data  <= data_w;
         end
      end
   end

   // Registered SDRAM-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd    <= C_NOP;
         r_ba     <= 2'd0;
         r_addr   <= 13'd0;
         r_dq_out <= 16'd0;
         r_dq_oe  <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_cmd    <= w_cmd;
         r_ba     <= w_ba;
         r_addr   <= w_addr;
         r_dq_out <= w_dq_out;
         r_dq_oe  <= w_dq_oe;
         r_done   <= w_done;
         r_busy   <= w_busy;
      end
   end

   assign cmd    = r_cmd;
   assign ba     = r_ba;
   assign addr   = r_addr;
   assign dq_out = r_dq_out;
   assign dq_oe  = r_dq_oe;
   assign done_w = r_done;
   assign busy   = r_busy;

endmodule

// File: tb/tb_sdr_write.sv
// -----------------------------------------------------------------------------
// tb_sdr_write
//   Directed bench for sdr_write. Two instances share the request inputs: one
//   with default timing (2/2/2) and one with T_RCD=3, T_WR=1, T_RP=3. Outputs
//   are captured one time unit after each rising edge; cycle 0 is the first
//   cycle after the edge that accepts the request.
// -----------------------------------------------------------------------------
module tb_sdr_write;

   localparam logic [3:0] NOP = 4'b0111;
   localparam logic [3:0] ACT = 4'b0011;
   localparam logic [3:0] WRC = 4'b0100;
   localparam logic [3:0] PRE = 4'b0010;
   localparam int         NCYC = 16;

   logic        clk;
   logic        rst_n;
   logic        req_w;
   logic [24:0] laddr_w;
   logic [63:0] data_w;

   logic        a_done, a_busy, a_oe;
   logic [3:0]  a_cmd;
   logic [1:0]  a_ba;
   logic [12:0] a_addr;
   logic [15:0] a_dq;
   logic        b_done, b_busy, b_oe;
   logic [3:0]  b_cmd;
   logic [1:0]  b_ba;
   logic [12:0] b_addr;
   logic [15:0] b_dq;

   logic [3:0]  cap_a_cmd  [0:NCYC-1];
   logic [1:0]  cap_a_ba   [0:NCYC-1];
   logic [12:0] cap_a_addr [0:NCYC-1];
   logic [15:0] cap_a_dq   [0:NCYC-1];
   logic        cap_a_oe   [0:NCYC-1];
   logic        cap_a_done [0:NCYC-1];
   logic        cap_a_busy [0:NCYC-1];
   logic [3:0]  cap_b_cmd  [0:NCYC-1];
   logic        cap_b_done [0:NCYC-1];
   logic        cap_b_busy [0:NCYC-1];

   int n_checks = 0;
   int n_errors = 0;

`ifdef SDR_WR_AUTOPRE_EN
   localparam logic [12:0] AP_BIT = 13'h0400;
   localparam bit          EXPL_PRE = 1'b0;
`else
   localparam logic [12:0] AP_BIT = 13'h0000;
   localparam bit          EXPL_PRE = 1'b1;
`endif

   sdr_write u_dut_a (
      .clk(clk), .rst_n(rst_n), .req_w(req_w), .laddr_w(laddr_w), .data_w(data_w),
      .done_w(a_done), .busy(a_busy), .cmd(a_cmd), .ba(a_ba), .addr(a_addr),
      .dq_out(a_dq), .dq_oe(a_oe)
   );

   sdr_write #(.T_RCD(3), .T_WR(1), .T_RP(3)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .req_w(req_w), .laddr_w(laddr_w), .data_w(data_w),
      .done_w(b_done), .busy(b_busy), .cmd(b_cmd), .ba(b_ba), .addr(b_addr),
      .dq_out(b_dq), .dq_oe(b_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request and capture NCYC cycles of both instances.
   // req_w drops after the sample of cycle drop_at; inputs are scrambled
   // after the sample of cycle chg_at (negative disables).
   task automatic run_seq(input logic [24:0] la, input logic [63:0] dat,
                          input int drop_at, input int chg_at);
      laddr_w = la;
      data_w  = dat;
      req_w   = 1'b1;
      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         cap_a_cmd[c]  = a_cmd;
         cap_a_ba[c]   = a_ba;
         cap_a_addr[c] = a_addr;
         cap_a_dq[c]   = a_dq;
         cap_a_oe[c]   = a_oe;
         cap_a_done[c] = a_done;
         cap_a_busy[c] = a_busy;
         cap_b_cmd[c]  = b_cmd;
         cap_b_done[c] = b_done;
         cap_b_busy[c] = b_busy;
         if (c == drop_at) req_w = 1'b0;
         if (c == chg_at) begin
            laddr_w = 25'h1FF_FFFF;
            data_w  = 64'hDEAD_BEEF_CAFE_F00D;
         end
      end
   endtask

   // Default-timing instance: full cycle-by-cycle comparison.
   task automatic check_a(input string t, input logic [1:0] e_ba, input logic [12:0] e_row,
                          input logic [12:0] e_col, input logic [63:0] e_dat);
      int ndone;
      logic [3:0] e_cmd;
      ndone = 0;
      for (int c = 0; c < NCYC; c++) begin
         e_cmd = NOP;
         if (c == 0) e_cmd = ACT;
         if (c == 2) e_cmd = WRC;
         if (c == 8 && EXPL_PRE) e_cmd = PRE;
         chk($sformatf("%s_cmd@%0d", t, c), cap_a_cmd[c], e_cmd);
         chk($sformatf("%s_busy@%0d", t, c), cap_a_busy[c], (c <= 10) ? 1'b1 : 1'b0);
         chk($sformatf("%s_oe@%0d", t, c), cap_a_oe[c], (c >= 2 && c <= 5) ? 1'b1 : 1'b0);
         ndone += int'(cap_a_done[c]);
      end
      chk({t, "_act_ba"},   cap_a_ba[0],   e_ba);
      chk({t, "_act_row"},  cap_a_addr[0], e_row);
      chk({t, "_wr_ba"},    cap_a_ba[2],   e_ba);
      chk({t, "_wr_addr"},  cap_a_addr[2], e_col | AP_BIT);
      chk({t, "_pre_ba"},   cap_a_ba[8],   EXPL_PRE ? e_ba : 2'd0);
      chk({t, "_pre_a10"},  cap_a_addr[8], 13'h0000);
      chk({t, "_beat0"},    cap_a_dq[2],   e_dat[15:0]);
      chk({t, "_beat1"},    cap_a_dq[3],   e_dat[31:16]);
      chk({t, "_beat2"},    cap_a_dq[4],   e_dat[47:32]);
      chk({t, "_beat3"},    cap_a_dq[5],   e_dat[63:48]);
      chk({t, "_done@10"},  cap_a_done[10], 1'b1);
      chk({t, "_done_cnt"}, ndone, 1);
   endtask

   initial begin
      rst_n   = 1'b0;
      req_w   = 1'b0;
      laddr_w = 25'd0;
      data_w  = 64'd0;

      // 1: reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd",  a_cmd,  NOP);
      chk("rst_oe",   a_oe,   1'b0);
      chk("rst_done", a_done, 1'b0);
      chk("rst_busy", a_busy, 1'b0);
      chk("rst_addr", a_addr, 13'd0);
      chk("rst_dq",   a_dq,   16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 2: basic write, bank 0 row 0x295 column 0x004; req dropped after ACT
      run_seq(25'h0A_5404, 64'h4444_3333_2222_1111, 0, -1);
      check_a("t2", 2'd0, 13'h0295, 13'h0004, 64'h4444_3333_2222_1111);

      // 3: slow-timing instance from the same run
      begin
         int nb;
         nb = 0;
         for (int c = 0; c < NCYC; c++) nb += int'(cap_b_done[c]);
         chk("t3_act@0",   cap_b_cmd[0],  ACT);
         chk("t3_nop@2",   cap_b_cmd[2],  NOP);
         chk("t3_wr@3",    cap_b_cmd[3],  WRC);
         chk("t3_pre@8",   cap_b_cmd[8],  EXPL_PRE ? PRE : NOP);
         chk("t3_done@10", cap_b_done[10], 1'b0);
         chk("t3_done@11", cap_b_done[11], 1'b1);
         chk("t3_done_cnt", nb, 1);
         chk("t3_busy@11", cap_b_busy[11], 1'b1);
         chk("t3_busy@12", cap_b_busy[12], 1'b0);
      end

      // 4: req held through DONE, dropped the following cycle
      run_seq(25'h0A_5404, 64'h8888_7777_6666_5555, 11, -1);
      check_a("t4", 2'd0, 13'h0295, 13'h0004, 64'h8888_7777_6666_5555);
      for (int c = 11; c < NCYC; c++) begin
         chk($sformatf("t4_idle_cmd@%0d", c), cap_a_cmd[c], NOP);
      end

      // 5: inputs changed and req dropped at cycle 3; bank 3, col 0x0AB -> 0x0A8
      run_seq(25'h1A3_F8AB, 64'h0123_4567_89AB_CDEF, 3, 3);
      check_a("t5", 2'd3, 13'h08FE, 13'h00A8, 64'h0123_4567_89AB_CDEF);

      // 6: asynchronous reset mid-burst, then a fresh request
      laddr_w = 25'h0A_5404;
      data_w  = 64'h4444_3333_2222_1111;
      req_w   = 1'b1;
      for (int c = 0; c <= 4; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) begin
            chk("t6_act@0", a_cmd, ACT);
            req_w = 1'b0;
         end
      end
      chk("t6_oe_before", a_oe, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_cmd",  a_cmd,  NOP);
      chk("t6_rst_oe",   a_oe,   1'b0);
      chk("t6_rst_dq",   a_dq,   16'd0);
      chk("t6_rst_busy", a_busy, 1'b0);
      chk("t6_rst_ba",   a_ba,   2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("t6_no_resume_busy", a_busy, 1'b0);
      chk("t6_no_resume_done", a_done, 1'b0);
      run_seq(25'h0A_5404, 64'h4444_3333_2222_1111, 0, -1);
      check_a("t6", 2'd0, 13'h0295, 13'h0004, 64'h4444_3333_2222_1111);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
